uart_apb_fifo: RTL and testbench
================================

UART_APB_FIFO -- requirements
Module: uart_apb_fifo

Interface
REQ-001 SHALL have parameter TXFF_DEPTH, default 16, TX FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter RXFF_DEPTH, default 16, RX FIFO entries (power of 2, 4..256).
REQ-003 SHALL have parameter DATA_W, default 9, UART character width (8 or 9).
REQ-004 SHALL have ports: pclk  in  1  sole clock; prst  in  1  synchronous active-high reset.
REQ-005 SHALL have APB ports: psel, penable, pwrite  in  1 each; paddr  in  8; pwdata  in  32; prdata  out  32; pready  out  1; pslverr  out  1.
REQ-006 SHALL have TX core ports: tx_data  out  DATA_W  FIFO head; tx_valid  out  1  TX FIFO not empty and enabled; tx_rd  in  1  pop request.
REQ-007 SHALL have RX core ports: rx_data  in  DATA_W; rx_wr  in  1  push strobe; rx_fe, rx_pe  in  1  frame/parity error pulses; tx_busy, rx_busy  in  1.
REQ-008 SHALL have config outputs: uart_en, uart_d9, uart_bsel, uart_af  out  1 each; uart_brg  out  16; uart_if  out  1  combined interrupt.

Function
REQ-009 SHALL define access as psel&penable; pready tied 1; writes commit at the pclk edge ending the access.
REQ-010 SHALL decode paddr[7:0]: 0x00 CON, 0x04 SE, 0x08 BRG, 0x0C DATA, 0x10 IE, 0x14 ISR, 0x18 THR, 0x1C LVL.
REQ-011 SHALL drive pslverr=1 and prdata=0 during access to any other offset; no state change.
REQ-012 CON: bit0 af (RW); bit1 TX flush, bit2 RX flush, both write-1 self-clearing, read 0.
REQ-013 SE: bits[2:0] en,d9,bsel (RW); RO bit5 tx_not_full, bit6 rx_not_empty, bit7 tx_busy|rx_busy.
REQ-014 BRG: bits[15:0]; write ignored while uart_en=1.
REQ-015 DATA write: push pwdata[DATA_W-1:0] to TX FIFO if not full; if full, drop and set ISR.txov.
REQ-016 DATA read: prdata = RX head zero-extended, pop at access edge; if empty, prdata=0, no pop, set ISR.rxur.
REQ-017 THR: bits[7:0] tx_thr, bits[15:8] rx_thr; reset 0 and 1 respectively.
REQ-018 LVL (RO): bits[8:0] TX level, bits[24:16] RX level, range 0..DEPTH.
REQ-019 ISR: bit0 txlow = TX level <= tx_thr (level, RO); bit1 rxhi = RX level >= rx_thr and rx_thr!=0 (level, RO).
REQ-020 ISR sticky bits: bit2 rxov (push to full RX), bit3 fe, bit4 pe, bit5 txov, bit6 rxur; write 1 clears.
REQ-021 Same-cycle set and W1C of a sticky bit SHALL leave it set.
REQ-022 IE: bits[6:0] mask ISR bits; uart_if = |(ISR & IE), registered, 1-cycle latency from ISR.
REQ-023 tx_valid = uart_en & TX not empty; tx_rd with tx_valid=0 SHALL be ignored.
REQ-024 tx_data SHALL reflect the head combinationally; after pop, next entry visible the following cycle.
REQ-025 Push and pop in the same cycle on a non-empty, non-full FIFO SHALL leave the level unchanged.
REQ-026 Push to a full FIFO SHALL be dropped even if a pop occurs the same cycle.
REQ-027 Flush SHALL override a same-cycle push or pop and leave the FIFO empty next cycle.
REQ-028 Pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and index equal.
REQ-029 rx_wr with rx_fe/rx_pe SHALL still push the data and set the matching sticky bit.
REQ-030 uart_af = CON.af & uart_en; uart_en/d9/bsel = SE bits.

Reset
REQ-031 On prst=1 at a pclk edge: CON, SE, BRG, IE, sticky ISR = 0; THR = 0x0100; both FIFOs empty.
REQ-032 During reset: uart_if=0, tx_valid=0, pslverr=0; accesses and rx_wr ignored.
REQ-033 Reset asserted mid-stream SHALL discard FIFO contents; no partial pop/push completes.
REQ-034 FIFO storage arrays SHALL not require reset; only pointers and registers are reset.

Structure
REQ-035 Package uart_apb_pkg SHALL hold register offsets, ISR/IE bit indices, and THR reset value.
REQ-036 A sub-module uart_sync_fifo (params DEPTH, W; push, pop, flush, full, empty, level) SHALL be instantiated for TX and RX.
REQ-037 Register decode, ISR, and APB mux SHALL reside in uart_apb_fifo; no latches; the decode SHALL be a full case.

Verification
REQ-038 Reset, then read all offsets: CON=0, SE=0x20, BRG=0, IE=0, THR=0x0100, LVL=0, ISR=0x01.
REQ-039 uart_en=1, write 17 bytes 0x00..0x10 to DATA (depth 16): LVL.tx=16, ISR.txov=1; pop 16 via tx_rd -> 0x00..0x0F in order.
REQ-040 rx_thr=4, IE=0x02: push 4 RX bytes -> uart_if=1 one cycle after 4th push; read DATA 4x returns the pushed values, then a 5th read returns 0 with ISR.rxur=1.
REQ-041 TX FIFO holding 8: simultaneous DATA write and tx_rd -> LVL.tx stays 8; CON=0x02 with same-cycle push -> LVL.tx=0.
REQ-042 uart_en=1, write BRG=0x1234 -> BRG reads 0; en=0, write -> reads 0x1234; access offset 0x20 -> pslverr=1.
REQ-043 rx_wr with rx_fe=1 at the same cycle as W1C of ISR bit3 -> bit3 remains 1; next W1C clears it.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared register map, interrupt bit positions and reset constants for the
// UART APB FIFO block.
package uart_apb_pkg;

  localparam logic [7:0] OFF_CON  = 8'h00;
  localparam logic [7:0] OFF_SE   = 8'h04;
  localparam logic [7:0] OFF_BRG  = 8'h08;
  localparam logic [7:0] OFF_DATA = 8'h0C;
  localparam logic [7:0] OFF_IE   = 8'h10;
  localparam logic [7:0] OFF_ISR  = 8'h14;
  localparam logic [7:0] OFF_THR  = 8'h18;
  localparam logic [7:0] OFF_LVL  = 8'h1C;

  localparam int ISR_TXLOW = 0;
  localparam int ISR_RXHI  = 1;
  localparam int ISR_RXOV  = 2;
  localparam int ISR_FE    = 3;
  localparam int ISR_PE    = 4;
  localparam int ISR_TXOV  = 5;
  localparam int ISR_RXUR  = 6;

  localparam logic [6:0]  ISR_STICKY_MASK = 7'h7C;
  localparam logic [15:0] THR_RST         = 16'h0100;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is presented combinationally.
// Flush and reset clear the pointers only, storage is left untouched.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  // full is checked before any same-cycle pop, so a push into a full FIFO is lost
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge pclk) begin
    if (prst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB register front-end for a UART core: config registers, interrupt status,
// and TX/RX character FIFOs.
module uart_apb_fifo
  import uart_apb_pkg::*;
#(
  parameter int TXFF_DEPTH = 16,
  parameter int RXFF_DEPTH = 16,
  parameter int DATA_W     = 9
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_rd,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_wr,
  input  logic              rx_fe,
  input  logic              rx_pe,
  input  logic              tx_busy,
  input  logic              rx_busy,
  output logic              uart_en,
  output logic              uart_d9,
  output logic              uart_bsel,
  output logic              uart_af,
  output logic [15:0]       uart_brg,
  output logic              uart_if
);

  localparam int TXLW = $clog2(TXFF_DEPTH) + 1;
  localparam int RXLW = $clog2(RXFF_DEPTH) + 1;

  logic        con_af;
  logic [2:0]  se;
  logic [15:0] brg;
  logic [6:0]  ie;
  logic [7:0]  tx_thr, rx_thr;
  logic [6:0]  sticky, sticky_set, w1c, isr;
  logic        if_q;

  logic access, addr_ok, wr_acc, rd_acc;
  logic sel_con, sel_se, sel_brg, sel_data, sel_ie, sel_isr, sel_thr, sel_lvl;

  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_dout;
  logic [TXLW-1:0]   tx_level;
  logic [RXLW-1:0]   rx_level;
  logic [8:0]        tx_lvl9, rx_lvl9;
  logic              unused_pwdata;

  assign unused_pwdata = ^pwdata[31:16];

  always_comb begin
    {sel_con, sel_se, sel_brg, sel_data, sel_ie, sel_isr, sel_thr, sel_lvl} = '0;
    addr_ok = 1'b1;
    case (paddr)
      OFF_CON:  sel_con  = 1'b1;
      OFF_SE:   sel_se   = 1'b1;
      OFF_BRG:  sel_brg  = 1'b1;
      OFF_DATA: sel_data = 1'b1;
      OFF_IE:   sel_ie   = 1'b1;
      OFF_ISR:  sel_isr  = 1'b1;
      OFF_THR:  sel_thr  = 1'b1;
      OFF_LVL:  sel_lvl  = 1'b1;
      default:  addr_ok  = 1'b0;
    endcase
  end

  assign access  = psel & penable & ~prst;
  assign wr_acc  = access & pwrite & addr_ok;
  assign rd_acc  = access & ~pwrite & addr_ok;
  assign pready  = 1'b1;
  assign pslverr = access & ~addr_ok;

  assign tx_valid = se[0] & ~tx_empty & ~prst;
  assign tx_push  = wr_acc & sel_data;
  assign tx_pop   = tx_rd & tx_valid;
  assign tx_flush = wr_acc & sel_con & pwdata[1];
  assign rx_push  = rx_wr & ~prst;
  assign rx_pop   = rd_acc & sel_data;
  assign rx_flush = wr_acc & sel_con & pwdata[2];

  uart_sync_fifo #(.DEPTH(TXFF_DEPTH), .W(DATA_W)) u_tx_fifo (
    .pclk(pclk), .prst(prst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(pwdata[DATA_W-1:0]), .dout(tx_data), .full(tx_full), .empty(tx_empty),
    .level(tx_level)
  );

  uart_sync_fifo #(.DEPTH(RXFF_DEPTH), .W(DATA_W)) u_rx_fifo (
    .pclk(pclk), .prst(prst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
    .level(rx_level)
  );

  assign tx_lvl9 = 9'(tx_level);
  assign rx_lvl9 = 9'(rx_level);

  always_comb begin
    sticky_set = '0;
    sticky_set[ISR_RXOV] = rx_push & rx_full;
    sticky_set[ISR_FE]   = rx_fe & ~prst;
    sticky_set[ISR_PE]   = rx_pe & ~prst;
    sticky_set[ISR_TXOV] = tx_push & tx_full;
    sticky_set[ISR_RXUR] = rx_pop & rx_empty;
    w1c = (wr_acc && sel_isr) ? pwdata[6:0] : '0;
    isr = sticky & ISR_STICKY_MASK;
    isr[ISR_TXLOW] = (tx_lvl9 <= {1'b0, tx_thr});
    isr[ISR_RXHI]  = (rx_lvl9 >= {1'b0, rx_thr}) && (rx_thr != 8'd0);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      con_af           <= 1'b0;
      se               <= '0;
      brg              <= '0;
      ie               <= '0;
      {rx_thr, tx_thr} <= THR_RST;
      sticky           <= '0;
      if_q             <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (sel_con)           con_af <= pwdata[0];
        if (sel_se)            se     <= pwdata[2:0];
        if (sel_brg && !se[0]) brg    <= pwdata[15:0];
        if (sel_ie)            ie     <= pwdata[6:0];
        if (sel_thr) begin
          tx_thr <= pwdata[7:0];
          rx_thr <= pwdata[15:8];
        end
      end
      // a set in the same cycle as its clear wins
      sticky <= ((sticky & ~w1c) | sticky_set) & ISR_STICKY_MASK;
      if_q   <= |(isr & ie);
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (paddr)
        OFF_CON:  prdata = {31'b0, con_af};
        OFF_SE:   prdata = {24'b0, tx_busy | rx_busy, ~rx_empty, ~tx_full, 2'b0, se};
        OFF_BRG:  prdata = {16'b0, brg};
        OFF_DATA: prdata = rx_empty ? 32'b0 : {{(32-DATA_W){1'b0}}, rx_dout};
        OFF_IE:   prdata = {25'b0, ie};
        OFF_ISR:  prdata = {25'b0, isr};
        OFF_THR:  prdata = {16'b0, rx_thr, tx_thr};
        OFF_LVL:  prdata = {7'b0, rx_lvl9, 7'b0, tx_lvl9};
        default:  prdata = '0;
      endcase
    end
  end

  assign uart_en   = se[0];
  assign uart_d9   = se[1];
  assign uart_bsel = se[2];
  assign uart_af   = con_af & se[0];
  assign uart_brg  = brg;
  assign uart_if   = if_q & ~prst;

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Self-checking bench for uart_apb_fifo: reset-value table plus scoreboarded
// FIFO traffic and hand-written corner-case sequences.
module tb_uart_apb_fifo;
  import uart_apb_pkg::*;

  localparam int DW    = 9;
  localparam int DEPTH = 16;

  logic          pclk = 1'b0;
  logic          prst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]    paddr = '0;
  logic [31:0]   pwdata = '0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_rd = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_wr = 1'b0, rx_fe = 1'b0, rx_pe = 1'b0;
  logic          tx_busy = 1'b0, rx_busy = 1'b0;
  logic          uart_en, uart_d9, uart_bsel, uart_af, uart_if;
  logic [15:0]   uart_brg;

  always #5 pclk = ~pclk;

  uart_apb_fifo #(.TXFF_DEPTH(DEPTH), .RXFF_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_rd(tx_rd),
    .rx_data(rx_data), .rx_wr(rx_wr), .rx_fe(rx_fe), .rx_pe(rx_pe),
    .tx_busy(tx_busy), .rx_busy(rx_busy),
    .uart_en(uart_en), .uart_d9(uart_d9), .uart_bsel(uart_bsel), .uart_af(uart_af),
    .uart_brg(uart_brg), .uart_if(uart_if)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } rd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One APB access; optional tx_rd / rx_wr strobes share the access edge.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic txrd, input logic rxwr, input logic [DW-1:0] rxd,
                      input logic fe, output logic [31:0] rd, output logic err);
    logic [31:0] exp_v;
    bit          tx_full_pre, rx_full_pre;
    tx_full_pre = (txq.size() == DEPTH);
    rx_full_pre = (rxq.size() == DEPTH);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    tick();
    penable = 1'b1; tx_rd = txrd; rx_wr = rxwr; rx_data = rxd; rx_fe = fe;
    #1;
    rd  = prdata;
    err = pslverr;
    if (txrd) begin
      chk("tx_valid_acc", 32'(tx_valid), 32'd1);
      if (txq.size() > 0) chk("tx_head_acc", 32'(tx_data), 32'(txq.pop_front()));
    end
    if (!wr && a == OFF_DATA) begin
      exp_v = (rxq.size() > 0) ? 32'(rxq.pop_front()) : 32'd0;
      chk("rx_data_rd", rd, exp_v);
    end
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_rd = 1'b0; rx_wr = 1'b0; rx_fe = 1'b0;
    if (wr && a == OFF_DATA && !tx_full_pre) txq.push_back(wd[DW-1:0]);
    if (rxwr && !rx_full_pre) rxq.push_back(rxd);
    if (wr && a == OFF_CON) begin
      if (wd[1]) txq.delete();
      if (wd[2]) rxq.delete();
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] d;
    logic        e;
    xfer(1'b1, a, wd, 1'b0, 1'b0, '0, 1'b0, d, e);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp_v);
    logic [31:0] d;
    logic        e;
    xfer(1'b0, a, 32'd0, 1'b0, 1'b0, '0, 1'b0, d, e);
    chk(name, d, exp_v);
  endtask

  task automatic rx_push(input logic [DW-1:0] d, input logic fe, input logic pe);
    bit full_pre;
    full_pre = (rxq.size() == DEPTH);
    rx_wr = 1'b1; rx_data = d; rx_fe = fe; rx_pe = pe;
    tick();
    rx_wr = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
    if (!full_pre) rxq.push_back(d);
  endtask

  task automatic tx_pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      chk("tx_valid", 32'(tx_valid), 32'd1);
      if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
      tx_rd = 1'b1;
      tick();
    end
    tx_rd = 1'b0;
  endtask

  function automatic logic [31:0] exp_lvl();
    return (32'(rxq.size()) << 16) | 32'(txq.size());
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_vec_t     rst_tab[10];
    logic [31:0] d;
    logic        e;

    rst_tab[0] = '{OFF_CON, 32'h0, 1'b0};
    rst_tab[1] = '{OFF_SE,  32'h20, 1'b0};
    rst_tab[2] = '{OFF_BRG, 32'h0, 1'b0};
    rst_tab[3] = '{OFF_IE,  32'h0, 1'b0};
    rst_tab[4] = '{OFF_ISR, 32'h01, 1'b0};
    rst_tab[5] = '{OFF_THR, 32'h0100, 1'b0};
    rst_tab[6] = '{OFF_LVL, 32'h0, 1'b0};
    rst_tab[7] = '{8'h20,   32'h0, 1'b1};
    rst_tab[8] = '{8'h03,   32'h0, 1'b1};
    rst_tab[9] = '{8'hFC,   32'h0, 1'b1};

    repeat (3) tick();
    prst = 1'b0;
    tick();
    chk("rst_uart_if", 32'(uart_if), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, rst_tab[i].addr, 32'd0, 1'b0, 1'b0, '0, 1'b0, d, e);
      chk($sformatf("rst_rd_%0h", rst_tab[i].addr), d, rst_tab[i].exp_data);
      chk($sformatf("rst_err_%0h", rst_tab[i].addr), 32'(e), 32'(rst_tab[i].exp_err));
    end

    // TX fill past full, then drain in order
    apb_wr(OFF_SE, 32'h1);
    chk("uart_en", 32'(uart_en), 32'd1);
    for (int i = 0; i <= 16; i++) apb_wr(OFF_DATA, 32'(i));
    rd_chk("lvl_tx_full", OFF_LVL, 32'h10);
    chk("lvl_model", 32'h10, exp_lvl());
    rd_chk("isr_txov", OFF_ISR, 32'h20);
    tx_pop_n(16);
    chk("tx_valid_empty", 32'(tx_valid), 32'd0);
    tx_rd = 1'b1;
    tick();
    tx_rd = 1'b0;
    rd_chk("lvl_after_drain", OFF_LVL, 32'h0);
    apb_wr(OFF_ISR, 32'h7F);
    rd_chk("isr_cleared", OFF_ISR, 32'h01);

    // RX threshold interrupt and underrun
    apb_wr(OFF_THR, 32'h0400);
    apb_wr(OFF_IE, 32'h02);
    rx_push(9'h0A5, 1'b0, 1'b0);
    rx_push(9'h1C3, 1'b0, 1'b0);
    rx_push(9'h03C, 1'b0, 1'b0);
    rx_push(9'h0FF, 1'b0, 1'b0);
    chk("uart_if_latency0", 32'(uart_if), 32'd0);
    tick();
    chk("uart_if_latency1", 32'(uart_if), 32'd1);
    rd_chk("lvl_rx4", OFF_LVL, exp_lvl());
    for (int i = 0; i < 5; i++) xfer(1'b0, OFF_DATA, 32'd0, 1'b0, 1'b0, '0, 1'b0, d, e);
    rd_chk("isr_rxur", OFF_ISR, 32'h41);
    tick();
    chk("uart_if_masked", 32'(uart_if), 32'd0);
    apb_wr(OFF_ISR, 32'h40);
    rd_chk("isr_rxur_clr", OFF_ISR, 32'h01);
    apb_wr(OFF_IE, 32'h0);

    // simultaneous push/pop, then flush overriding same-cycle traffic
    for (int i = 0; i < 8; i++) apb_wr(OFF_DATA, 32'h50 + 32'(i));
    rd_chk("lvl_tx8", OFF_LVL, 32'h8);
    xfer(1'b1, OFF_DATA, 32'h58, 1'b1, 1'b0, '0, 1'b0, d, e);
    rd_chk("lvl_pushpop", OFF_LVL, 32'h8);
    rx_push(9'h011, 1'b0, 1'b0);
    rx_push(9'h022, 1'b0, 1'b0);
    rd_chk("lvl_tx8_rx2", OFF_LVL, 32'h0002_0008);
    xfer(1'b1, OFF_CON, 32'h06, 1'b1, 1'b1, 9'h033, 1'b0, d, e);
    rd_chk("lvl_flushed", OFF_LVL, 32'h0);
    chk("tx_valid_flushed", 32'(tx_valid), 32'd0);

    // auto-flow, baud rate lock, bad offset
    apb_wr(OFF_CON, 32'h01);
    chk("uart_af_on", 32'(uart_af), 32'd1);
    rd_chk("con_af", OFF_CON, 32'h01);
    apb_wr(OFF_SE, 32'h0);
    chk("uart_af_en0", 32'(uart_af), 32'd0);
    apb_wr(OFF_SE, 32'h1);
    apb_wr(OFF_BRG, 32'h1234);
    rd_chk("brg_locked", OFF_BRG, 32'h0);
    apb_wr(OFF_SE, 32'h0);
    apb_wr(OFF_BRG, 32'h1234);
    rd_chk("brg_written", OFF_BRG, 32'h1234);
    chk("uart_brg", 32'(uart_brg), 32'h1234);
    xfer(1'b1, 8'h20, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, d, e);
    chk("bad_wr_err", 32'(e), 32'd1);
    rd_chk("ie_unchanged", OFF_IE, 32'h0);
    apb_wr(OFF_SE, 32'h7);
    chk("se_outs", {29'b0, uart_bsel, uart_d9, uart_en}, 32'h7);
    tx_busy = 1'b1;
    rd_chk("se_busy", OFF_SE, 32'hA7);
    tx_busy = 1'b0;

    // sticky set beats same-cycle W1C
    xfer(1'b1, OFF_ISR, 32'h08, 1'b0, 1'b1, 9'h155, 1'b1, d, e);
    rd_chk("isr_fe_kept", OFF_ISR, 32'h09);
    apb_wr(OFF_ISR, 32'h08);
    rd_chk("isr_fe_clr", OFF_ISR, 32'h01);
    rx_push(9'h0AA, 1'b0, 1'b1);
    rd_chk("isr_pe", OFF_ISR, 32'h11);
    apb_wr(OFF_ISR, 32'h10);
    for (int i = 0; i < 2; i++) xfer(1'b0, OFF_DATA, 32'd0, 1'b0, 1'b0, '0, 1'b0, d, e);

    // RX overflow
    for (int i = 0; i <= 16; i++) rx_push(9'(i), 1'b0, 1'b0);
    rd_chk("lvl_rx_full", OFF_LVL, 32'h0010_0000);
    rd_chk("isr_rxov", OFF_ISR, 32'h07);
    for (int i = 0; i < 2; i++) xfer(1'b0, OFF_DATA, 32'd0, 1'b0, 1'b0, '0, 1'b0, d, e);
    apb_wr(OFF_CON, 32'h04);
    apb_wr(OFF_ISR, 32'h7F);

    // reset in the middle of traffic
    for (int i = 0; i < 3; i++) apb_wr(OFF_DATA, 32'h60 + 32'(i));
    apb_wr(OFF_THR, 32'h0408);
    apb_wr(OFF_IE, 32'h01);
    tick();
    chk("uart_if_txlow", 32'(uart_if), 32'd1);
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'h77;
    tick();
    penable = 1'b1; tx_rd = 1'b1; rx_wr = 1'b1; rx_data = 9'h0EE; prst = 1'b1;
    #1;
    chk("rst_mid_if", 32'(uart_if), 32'd0);
    chk("rst_mid_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_slverr", 32'(pslverr), 32'd0);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_rd = 1'b0; rx_wr = 1'b0;
    tick();
    prst = 1'b0;
    txq.delete();
    rxq.delete();
    tick();
    rd_chk("post_rst_lvl", OFF_LVL, 32'h0);
    rd_chk("post_rst_thr", OFF_THR, 32'h0100);
    rd_chk("post_rst_se", OFF_SE, 32'h20);
    rd_chk("post_rst_isr", OFF_ISR, 32'h01);
    chk("post_rst_if", 32'(uart_if), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
